// File: rtl/line_buffer_ctrl.sv
// Ping-pong line RAM sequencer: the ADC writer fills one bank while the
// readout side drains the other through a 2-entry skid queue.
module line_buffer_ctrl #(
    parameter int addr_width = 8,
    parameter int data_width = 16,
    parameter int line_len   = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  line_start,
    input  logic                  pix_valid,
    input  logic [data_width-1:0] pix_data,
    output logic [data_width-1:0] ram_write_data,
    output logic [addr_width-1:0] ram_write_address,
    output logic                  ram_write_enable,
    output logic [addr_width-1:0] ram_read_address,
    input  logic [data_width-1:0] ram_read_data,
    output logic [data_width-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [1:0]            banks_full,
    output logic                  overflow,
    input  logic                  overflow_clr,
    output logic [1:0]            wr_state_dbg,
    output logic                  rd_state_dbg
);

    // Handshake: a word moves downstream on every clk edge where
    // out_valid && out_ready; out_data/out_last hold while out_valid && !out_ready.

    localparam int cw = addr_width - 1;
    localparam logic [cw-1:0] last_idx = cw'(line_len - 1);
    localparam logic [cw-1:0] cnt_one  = cw'(1);

    typedef enum logic [1:0] {
        WAIT_START = 2'd0,
        FILL       = 2'd1,
        DROP       = 2'd2
    } wr_state_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_t;

    // ---------------- writer ----------------
    wr_state_t     wr_state;
    logic          wbank;
    logic [cw-1:0] wcount;

    logic          start_ok;
    logic          wr_fire;
    logic [cw-1:0] wr_addr_lo;
    logic          wr_line_done;
    logic          drop_event;
    logic [1:0]    full_set;

    assign start_ok     = line_start && !banks_full[wbank];
    assign wr_fire      = !reset && pix_valid && ((wr_state == FILL) || start_ok);
    // A line_start restarts the line, so its coincident pixel lands at offset 0.
    assign wr_addr_lo   = line_start ? '0 : wcount;
    assign wr_line_done = wr_fire && !line_start && (wcount == last_idx);
    assign drop_event   = !reset && line_start && (wr_state != FILL) && banks_full[wbank];

    assign full_set[0]  = wr_line_done && !wbank;
    assign full_set[1]  = wr_line_done && wbank;

    assign ram_write_enable  = wr_fire;
    assign ram_write_address = wr_fire ? {wbank, wr_addr_lo} : '0;
    assign ram_write_data    = wr_fire ? pix_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state <= WAIT_START;
            wbank    <= 1'b0;
            wcount   <= '0;
        end else begin
            case (wr_state)
                WAIT_START, DROP: begin
                    if (line_start) begin
                        if (banks_full[wbank]) begin
                            wr_state <= DROP;
                        end else begin
                            wr_state <= FILL;
                            wcount   <= pix_valid ? cnt_one : '0;
                        end
                    end
                end
                FILL: begin
                    if (line_start) begin
                        wcount <= pix_valid ? cnt_one : '0;
                    end else if (pix_valid) begin
                        if (wcount == last_idx) begin
                            wr_state <= WAIT_START;
                            wbank    <= ~wbank;
                            wcount   <= '0;
                        end else begin
                            wcount <= wcount + cnt_one;
                        end
                    end
                end
                default: wr_state <= WAIT_START;
            endcase
        end
    end

    // ---------------- reader ----------------
    // The issue side (ibank/icount) runs ahead of the accept side (rbank) so the
    // next full bank is prefetched before the current line's last word leaves.
    rd_state_t             rd_state;
    logic                  rbank;
    logic                  ibank;
    logic [cw-1:0]         icount;
    logic                  rd_pending;
    logic                  pend_last;
    logic [1:0]            occ;
    logic [data_width-1:0] q_data [2];
    logic [1:0]            q_last;

    logic       accept;
    logic       last_accept;
    logic [2:0] used;
    logic       rd_issue;
    logic       issue_last;
    logic [1:0] full_clr;

    assign out_valid   = (occ != 2'd0);
    assign out_data    = q_data[0];
    assign out_last    = out_valid && q_last[0];
    assign accept      = out_valid && out_ready;
    assign last_accept = accept && q_last[0];

    // Slots freed by this cycle's acceptance count, which keeps 1 word/cycle.
    assign used        = {1'b0, occ} + {2'b00, rd_pending} - {2'b00, accept};
    assign rd_issue    = !reset && banks_full[ibank] && (used < 3'd2);
    assign issue_last  = (icount == last_idx);

    assign ram_read_address = {ibank, icount};

    assign full_clr[0] = last_accept && !rbank;
    assign full_clr[1] = last_accept && rbank;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state   <= IDLE;
            rbank      <= 1'b0;
            ibank      <= 1'b0;
            icount     <= '0;
            rd_pending <= 1'b0;
            pend_last  <= 1'b0;
            occ        <= 2'd0;
            q_data[0]  <= '0;
            q_data[1]  <= '0;
            q_last     <= 2'b00;
        end else begin
            case (rd_state)
                IDLE:    if (banks_full[rbank]) rd_state <= STREAM;
                STREAM:  if (last_accept) rd_state <= IDLE;
                default: rd_state <= IDLE;
            endcase

            if (last_accept) begin
                rbank <= ~rbank;
            end

            if (rd_issue) begin
                if (issue_last) begin
                    icount <= '0;
                    ibank  <= ~ibank;
                end else begin
                    icount <= icount + cnt_one;
                end
            end
            rd_pending <= rd_issue;
            pend_last  <= rd_issue && issue_last;

            case ({rd_pending, accept})
                2'b10: begin
                    q_data[occ[0]] <= ram_read_data;
                    q_last[occ[0]] <= pend_last;
                    occ            <= occ + 2'd1;
                end
                2'b01: begin
                    q_data[0] <= q_data[1];
                    q_last[0] <= q_last[1];
                    occ       <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        q_data[0] <= ram_read_data;
                        q_last[0] <= pend_last;
                    end else begin
                        q_data[0] <= q_data[1];
                        q_last[0] <= q_last[1];
                        q_data[1] <= ram_read_data;
                        q_last[1] <= pend_last;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- shared flags ----------------
    // Set and clear always target different banks, so both apply in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            banks_full <= 2'b00;
            overflow   <= 1'b0;
        end else begin
            banks_full <= (banks_full & ~full_clr) | full_set;
            if (drop_event) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign wr_state_dbg = wr_state;
    assign rd_state_dbg = rd_state;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: RAM model, line-level reference model with an
// expected output queue, and directed plus randomized scenarios.
module tb_line_buffer_ctrl;

    localparam int aw = 8;
    localparam int dw = 16;
    localparam int ll = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          line_start = 1'b0;
    logic          pix_valid = 1'b0;
    logic [dw-1:0] pix_data = '0;
    logic [dw-1:0] ram_write_data;
    logic [aw-1:0] ram_write_address;
    logic          ram_write_enable;
    logic [aw-1:0] ram_read_address;
    logic [dw-1:0] ram_read_data;
    logic [dw-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic [1:0]    banks_full;
    logic          overflow;
    logic          overflow_clr = 1'b0;
    logic [1:0]    wr_state_dbg;
    logic          rd_state_dbg;

    line_buffer_ctrl #(.addr_width(aw), .data_width(dw), .line_len(ll)) dut (
        .clk               (clk),
        .reset             (reset),
        .line_start        (line_start),
        .pix_valid         (pix_valid),
        .pix_data          (pix_data),
        .ram_write_data    (ram_write_data),
        .ram_write_address (ram_write_address),
        .ram_write_enable  (ram_write_enable),
        .ram_read_address  (ram_read_address),
        .ram_read_data     (ram_read_data),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_last          (out_last),
        .banks_full        (banks_full),
        .overflow          (overflow),
        .overflow_clr      (overflow_clr),
        .wr_state_dbg      (wr_state_dbg),
        .rd_state_dbg      (rd_state_dbg)
    );

    // ---------------- clock and RAM ----------------
    always #5 clk = ~clk;

    logic [dw-1:0] mem [1<<aw];
    always @(posedge clk) begin
        if (ram_write_enable) mem[ram_write_address] <= ram_write_data;
        ram_read_data <= mem[ram_read_address];
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard and reference model ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [dw:0] exp_q[$];          // {last, data}
    logic [dw-1:0] m_line[$];
    bit       m_filling;
    bit       m_wbank;
    bit       m_rbank;
    int       m_pos;
    bit [1:0] m_full;
    bit       m_ovf;
    int       n_acc;
    int       pat_idx;
    bit       last_valid;
    bit       prev_stall;
    logic [dw-1:0] prev_data;
    logic     prev_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic bit ready_of(input int mode);
        bit r;
        case (mode)
            0:       r = 1'b0;
            1:       r = 1'b1;
            2:       r = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
            default: r = ($urandom_range(0, 99) < 60);
        endcase
        pat_idx++;
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_line.delete();
        m_filling = 0; m_wbank = 0; m_rbank = 0; m_pos = 0;
        m_full = 2'b00; m_ovf = 0; prev_stall = 0;
    endtask

    // One clock: drive at posedge+1, check at negedge, advance the model.
    task automatic cycle(input bit ls, input bit pv, input logic [dw-1:0] pd,
                         input int mode, input bit clr);
        bit rdy, exp_we, acc, acc_last, drop_now;
        int exp_addr;
        logic [dw:0] e;
        rdy = ready_of(mode);
        line_start = ls; pix_valid = pv; pix_data = pd;
        out_ready = rdy; overflow_clr = clr;
        @(negedge clk);
        exp_we = pv && (m_filling || (ls && !m_full[m_wbank]));
        check("wr_en", ram_write_enable, exp_we);
        if (exp_we) begin
            exp_addr = m_wbank * ll + (ls ? 0 : m_pos);
            check("wr_addr", ram_write_address, exp_addr);
            check("wr_data", ram_write_data, pd);
        end
        check("banks_full", banks_full, m_full);
        check("overflow", overflow, m_ovf);
        if (prev_stall) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_data", out_data, prev_data);
            check("stall_last", out_last, prev_last);
        end
        acc = out_valid && rdy;
        acc_last = 0;
        drop_now = 0;
        last_valid = out_valid;
        if (acc) begin
            check("word_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_data", out_data, e[dw-1:0]);
                check("out_last", out_last, e[dw]);
                acc_last = e[dw];
            end
            n_acc++;
        end
        prev_stall = out_valid && !rdy;
        prev_data = out_data;
        prev_last = out_last;
        // writer decisions see the full flags as they were before this edge
        if (ls) begin
            if (!m_filling && m_full[m_wbank]) begin
                m_ovf = 1; drop_now = 1;
            end else begin
                m_filling = 1; m_line.delete(); m_pos = 0;
                if (pv) begin m_line.push_back(pd); m_pos = 1; end
            end
        end else if (m_filling && pv) begin
            m_line.push_back(pd);
            m_pos++;
            if (m_pos == ll) begin
                for (int i = 0; i < ll; i++) exp_q.push_back({(i == ll - 1), m_line[i]});
                m_full[m_wbank] = 1;
                m_wbank = ~m_wbank;
                m_filling = 0;
                m_pos = 0;
            end
        end
        if (acc_last) begin
            m_full[m_rbank] = 0;
            m_rbank = ~m_rbank;
        end
        if (clr && !drop_now) m_ovf = 0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1; line_start = 0; pix_valid = 0; pix_data = '0;
        out_ready = 0; overflow_clr = 0;
        @(posedge clk); #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_data", out_data, 16'h0);
        check("rst_banks_full", banks_full, 2'b00);
        check("rst_overflow", overflow, 1'b0);
        check("rst_wr_en", ram_write_enable, 1'b0);
        check("rst_wr_addr", ram_write_address, 8'h00);
        check("rst_rd_addr", ram_read_address, 8'h00);
        check("rst_wr_state", wr_state_dbg, 2'd0);
        check("rst_rd_state", rd_state_dbg, 1'b0);
        @(posedge clk); #1;
        reset = 0;
        model_reset();
    endtask

    // kind 0: base+i sequence; kind 1: random pixels. gaps inserts idle cycles.
    task automatic write_line(input int mode, input int kind, input logic [dw-1:0] base,
                              input bit gaps);
        int sent;
        logic [dw-1:0] d;
        cycle(1'b1, 1'b0, '0, mode, 1'b0);
        sent = 0;
        while (sent < ll) begin
            if (gaps && $urandom_range(0, 99) < 30) begin
                cycle(1'b0, 1'b0, 16'($urandom), mode, 1'b0);
            end else begin
                d = (kind == 0) ? base + 16'(sent) : 16'($urandom);
                cycle(1'b0, 1'b1, d, mode, 1'b0);
                sent++;
            end
        end
    endtask

    task automatic drain(input int mode, input int budget, output int gaps);
        bit seen;
        int b;
        seen = 0; gaps = 0; b = budget;
        while (exp_q.size() > 0 && b > 0) begin
            cycle(1'b0, 1'b0, '0, mode, 1'b0);
            if (last_valid) seen = 1;
            else if (seen && exp_q.size() > 0) gaps++;
            b--;
        end
        check("drained", exp_q.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int gaps, base_acc, budget;
        bit found;
        logic [dw-1:0] d;
        model_reset();
        n_acc = 0; pat_idx = 0; last_valid = 0;

        // T1: reset, one sequential line, latency, full stream
        do_reset();
        write_line(1, 0, 16'h0000, 1'b0);
        cycle(1'b0, 1'b0, '0, 1, 1'b0);
        check("t1_lat_edge1", last_valid, 1'b0);
        cycle(1'b0, 1'b0, '0, 1, 1'b0);
        check("t1_lat_edge2", last_valid, 1'b0);
        cycle(1'b0, 1'b0, '0, 1, 1'b0);
        check("t1_lat_edge3", last_valid, 1'b1);
        drain(1, 300, gaps);
        check("t1_count", n_acc, 128);
        check("t1_full_clear", banks_full, 2'b00);

        // T2: three lines with readout stalled, third is dropped
        write_line(0, 1, '0, 1'b0);
        write_line(0, 1, '0, 1'b0);
        check("t2_both_full", banks_full, 2'b11);
        write_line(0, 1, '0, 1'b0);
        check("t2_overflow", overflow, 1'b1);
        base_acc = n_acc;
        drain(1, 600, gaps);
        check("t2_no_bubble", gaps, 0);
        check("t2_count", n_acc - base_acc, 256);
        cycle(1'b0, 1'b0, '0, 1, 1'b1);
        check("t2_ovf_clr", overflow, 1'b0);

        // T3: ready toggled 1,0,0,1
        base_acc = n_acc;
        pat_idx = 0;
        write_line(2, 1, '0, 1'b0);
        drain(2, 800, gaps);
        check("t3_count", n_acc - base_acc, 128);

        // T4: partial line then a full line starting with line_start+pixel
        base_acc = n_acc;
        cycle(1'b1, 1'b0, '0, 1, 1'b0);
        for (int i = 0; i < 50; i++) cycle(1'b0, 1'b1, 16'($urandom), 1, 1'b0);
        for (int i = 0; i < ll; i++) cycle((i == 0), 1'b1, 16'h4000 + 16'(i), 1, 1'b0);
        drain(1, 300, gaps);
        check("t4_count", n_acc - base_acc, 128);

        // T5: bank 1 completes on the edge bank 0's last word is accepted
        do_reset();
        write_line(0, 1, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, 0, 1'b0);
        for (int i = 0; i < ll - 1; i++) cycle(1'b0, 1'b1, 16'h8000 + 16'(i), 0, 1'b0);
        check("t5_pre_full", banks_full, 2'b01);
        found = 0;
        budget = 300;
        while (!found && budget > 0) begin
            if (out_valid && out_last) found = 1;
            else cycle(1'b0, 1'b0, '0, 1, 1'b0);
            budget--;
        end
        check("t5_found_last", found, 1'b1);
        cycle(1'b0, 1'b1, 16'h807F, 1, 1'b0);
        check("t5_swap_full", banks_full, 2'b10);
        drain(1, 300, gaps);

        // T6: reset mid-stream at word 60, then a clean line
        do_reset();
        write_line(0, 1, '0, 1'b0);
        base_acc = n_acc;
        budget = 300;
        while (n_acc - base_acc < 60 && budget > 0) begin
            cycle(1'b0, 1'b0, '0, 1, 1'b0);
            budget--;
        end
        check("t6_reached_60", n_acc - base_acc, 60);
        do_reset();
        base_acc = n_acc;
        write_line(1, 0, 16'h0100, 1'b0);
        drain(1, 300, gaps);
        check("t6_count", n_acc - base_acc, 128);

        // T7: random pixel gaps and random readout backpressure
        do_reset();
        for (int l = 0; l < 4; l++) write_line(3, 1, '0, 1'b1);
        drain(3, 3000, gaps);
        d = 16'($urandom);
        cycle(1'b0, 1'b0, d, 1, 1'b1);
        check("t7_idle_valid", out_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
